// File: rtl/stopwatch_ctrl.sv
// Front-panel controller for the stopwatch counter: button debounce, run-mode FSM,
// command pulses, lap snapshot and 4-digit display scan. Optional: STOPWATCH_CTRL_AUTOSTOP_EN.
module stopwatch_ctrl #(
  parameter int unsigned P_DEB_CNT   = 959999,
  parameter int unsigned P_PULSE_LEN = 4,
  parameter int unsigned P_SCAN_CNT  = 95999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic [3:0] t_10ms,
  input  logic [3:0] t_100ms,
  input  logic [3:0] t_1s,
  input  logic [3:0] t_10s,
  output logic       start_stop_n,
  output logic       clear_n,
  output logic [3:0] dig_sel,
  output logic [3:0] dig_val,
  output logic       dp,
  output logic       run_led,
  output logic       lap_led
);

  localparam int unsigned DEB_W    = 20;
  localparam int unsigned SCAN_W   = 17;
  localparam int unsigned BUSY_LEN = P_PULSE_LEN + 2;
  localparam int unsigned BUSY_W   = $clog2(BUSY_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t                 state;
  logic [1:0]             btn_raw;
  logic [1:0]             sync1;
  logic [1:0]             sync2;
  logic [1:0]             deb_lvl;
  logic [1:0]             press;
  logic [1:0][DEB_W-1:0]  deb_cnt;
  logic [BUSY_W-1:0]      busy_cnt;
  logic [3:0][3:0]        lap_dig;
  logic [3:0][3:0]        live_c;
  logic [3:0][3:0]        disp_c;
  logic [SCAN_W-1:0]      scan_cnt;
  logic [1:0]             scan_idx;
  logic                   busy_c;
  logic                   ss_evt_c;
  logic                   lap_evt_c;
  logic                   autostop_c;

  assign btn_raw = {btn_lap, btn_ss};
  assign live_c  = {t_10s, t_1s, t_100ms, t_10ms};

  // Synchronize, then accept a new level once it has held for P_DEB_CNT+1 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      deb_lvl <= '0;
      press   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(P_DEB_CNT)) begin
          deb_lvl[i] <= sync2[i];
          deb_cnt[i] <= '0;
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // START/STOP wins a tie with LAP/CLEAR
  assign ss_evt_c  = press[0];
  assign lap_evt_c = press[1] & ~press[0];
  assign busy_c    = (busy_cnt != '0);

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
  assign autostop_c = ((state == ST_RUN) || (state == ST_LAP)) && (live_c == 16'h9999);
`else
  assign autostop_c = 1'b0;
`endif

  // Mode FSM and command pulse generator; busy spans the low pulse plus two high cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      run_led      <= 1'b0;
      lap_led      <= 1'b0;
      lap_dig      <= '0;
      busy_cnt     <= '0;
      start_stop_n <= 1'b1;
      clear_n      <= 1'b1;
    end else if (busy_c) begin
      busy_cnt <= busy_cnt - BUSY_W'(1);
      if (busy_cnt <= BUSY_W'(3)) begin
        start_stop_n <= 1'b1;
        clear_n      <= 1'b1;
      end
    end else if (autostop_c || ss_evt_c) begin
      busy_cnt     <= BUSY_W'(BUSY_LEN);
      start_stop_n <= 1'b0;
      lap_led      <= 1'b0;
      if ((state == ST_IDLE) || (state == ST_STOP)) begin
        state   <= ST_RUN;
        run_led <= 1'b1;
      end else begin
        state   <= ST_STOP;
        run_led <= 1'b0;
      end
    end else if (lap_evt_c) begin
      case (state)
        ST_RUN: begin
          state   <= ST_LAP;
          lap_led <= 1'b1;
          lap_dig <= live_c;
        end
        ST_LAP: begin
          state   <= ST_RUN;
          lap_led <= 1'b0;
        end
        ST_STOP: begin
          state    <= ST_IDLE;
          run_led  <= 1'b0;
          busy_cnt <= BUSY_W'(BUSY_LEN);
          clear_n  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign disp_c = (state == ST_LAP) ? lap_dig : live_c;

  // Digit scan and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      dig_sel  <= 4'b1110;
      dig_val  <= '0;
      dp       <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_W'(P_SCAN_CNT)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      dig_sel <= ~(4'b0001 << scan_idx);
      dig_val <= disp_c[scan_idx];
      dp      <= (scan_idx == 2'd2);
    end
  end

endmodule
